// File: rtl/mem_stage.sv
// Y86 memory stage: performs the data-memory access an instruction needs over a
// req/ack bus and hands a registered result bundle to write-back.
module mem_stage #(
    parameter int          TIMEOUT = 16,
    parameter logic [7:0]  RNONE   = 8'h0F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  icode_i,
    input  logic [31:0] valE_i,
    input  logic [31:0] valA_i,
    input  logic [31:0] valP_i,
    input  logic [7:0]  dstE_i,
    input  logic [7:0]  dstM_i,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic        mem_err,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] valE_o,
    output logic [31:0] valM_o,
    output logic [7:0]  dstE_o,
    output logic [7:0]  dstM_o,
    output logic [1:0]  stat_o,
    output logic        halted
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          is_read;
    logic [31:0]   valE_lat;
    logic [7:0]    dstE_lat;
    logic [7:0]    dstM_lat;

    logic          dec_write;
    logic          dec_read;
    logic [31:0]   dec_addr;
    logic [31:0]   dec_wdata;
    logic          transfer;
    logic          timeout_hit;

    always_comb begin
        dec_write = 1'b0;
        dec_read  = 1'b0;
        dec_addr  = valE_i;
        dec_wdata = valA_i;
        case (icode_i)
            8'h4, 8'hA: dec_write = 1'b1;
            8'h8: begin
                dec_write = 1'b1;
                dec_wdata = valP_i;
            end
            8'h5: dec_read = 1'b1;
            8'h9, 8'hB: begin
                dec_read = 1'b1;
                dec_addr = valA_i;
            end
            default: ;
        endcase
    end

    // Accept only when idle and the output slot is empty or draining this cycle,
    // so a finishing access always finds the slot free.
    assign in_ready    = !rst && (state == IDLE) && !halted && (!out_valid || out_ready);
    assign transfer    = in_valid && in_ready;
    assign timeout_hit = (count == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            is_read   <= 1'b0;
            valE_lat  <= '0;
            dstE_lat  <= RNONE;
            dstM_lat  <= RNONE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            out_valid <= 1'b0;
            valE_o    <= '0;
            valM_o    <= '0;
            dstE_o    <= RNONE;
            dstM_o    <= RNONE;
            stat_o    <= STAT_AOK;
            halted    <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (transfer) begin
                        if (dec_write || dec_read) begin
                            state     <= ACCESS;
                            count     <= '0;
                            is_read   <= dec_read;
                            valE_lat  <= valE_i;
                            dstE_lat  <= dstE_i;
                            dstM_lat  <= dstM_i;
                            mem_req   <= 1'b1;
                            mem_we    <= dec_write;
                            mem_addr  <= dec_addr;
                            mem_wdata <= dec_wdata;
                        end else begin
                            out_valid <= 1'b1;
                            valE_o    <= valE_i;
                            valM_o    <= '0;
                            dstE_o    <= dstE_i;
                            dstM_o    <= dstM_i;
                            if (icode_i == 8'h0) begin
                                stat_o <= STAT_HLT;
                                halted <= 1'b1;
                            end else begin
                                stat_o <= STAT_AOK;
                            end
                        end
                    end
                end
                ACCESS: begin
                    // A good ack takes priority over a timeout reached in the same cycle.
                    if (mem_ack && !mem_err) begin
                        state     <= IDLE;
                        mem_req   <= 1'b0;
                        out_valid <= 1'b1;
                        valE_o    <= valE_lat;
                        valM_o    <= is_read ? mem_rdata : 32'h0;
                        dstE_o    <= dstE_lat;
                        dstM_o    <= dstM_lat;
                        stat_o    <= STAT_AOK;
                    end else if (mem_ack || timeout_hit) begin
                        state     <= IDLE;
                        mem_req   <= 1'b0;
                        out_valid <= 1'b1;
                        valE_o    <= valE_lat;
                        valM_o    <= '0;
                        dstE_o    <= RNONE;
                        dstM_o    <= RNONE;
                        stat_o    <= STAT_ADR;
                        halted    <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
